// File: rtl/proc_clock_ctrl.sv
// Clock-enable generator for the processor core: free-running divided enable or
// single-step enable from a debounced push-button, plus pulse counter and heartbeat.
module proc_clock_ctrl #(
  parameter int unsigned DIV      = 50000000,
  parameter int unsigned DEBOUNCE = 500000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic        KeyN,
  output logic        ClockEn,
  output logic [15:0] PulseCount,
  output logic        Heartbeat,
  output logic        StepMode,
  output logic        dbg_step_state
);

  typedef enum logic {
    WAIT_PRESS   = 1'b0,
    WAIT_RELEASE = 1'b1
  } step_state_e;

  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
  localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE - 1);

  logic        run_meta_q, run_meta_d;
  logic        run_s_q, run_s_d;
  logic        key_meta_q, key_meta_d;
  logic        key_s_q, key_s_d;
  logic        key_db_q, key_db_d;
  logic [23:0] dbc_q, dbc_d;
  step_state_e state_q, state_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic        clock_en_q, clock_en_d;
  logic [15:0] pulse_count_q, pulse_count_d;
  logic        heartbeat_q, heartbeat_d;
  logic        step_mode_q, step_mode_d;
  logic        run_pulse;
  logic        step_pulse;

  always_comb begin
    run_meta_d = Run;
    run_s_d    = run_meta_q;
    key_meta_d = ~KeyN;
    key_s_d    = key_meta_q;

    // Any sample that agrees with the accepted level restarts the stability count.
    key_db_d = key_db_q;
    dbc_d    = '0;
    if (key_s_q != key_db_q) begin
      if (dbc_q == DB_LAST) begin
        key_db_d = key_s_q;
      end else begin
        dbc_d = dbc_q + 24'd1;
      end
    end

    // A press is consumed on entry to WAIT_RELEASE, so holding the key never repeats.
    state_d    = state_q;
    step_pulse = 1'b0;
    case (state_q)
      WAIT_PRESS: begin
        if (key_db_q) begin
          state_d    = WAIT_RELEASE;
          step_pulse = ~run_s_q;
        end
      end
      WAIT_RELEASE: begin
        if (!key_db_q) state_d = WAIT_PRESS;
      end
      default: state_d = WAIT_PRESS;
    endcase

    run_pulse = run_s_q && (div_cnt_q == DIV_LAST);
    if (!run_s_q) begin
      div_cnt_d = '0;
    end else if (run_pulse) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 32'd1;
    end

    clock_en_d    = run_pulse | step_pulse;
    pulse_count_d = clock_en_q ? pulse_count_q + 16'd1 : pulse_count_q;
    heartbeat_d   = heartbeat_q ^ clock_en_q;
    step_mode_d   = ~run_s_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      run_meta_q    <= 1'b0;
      run_s_q       <= 1'b0;
      key_meta_q    <= 1'b0;
      key_s_q       <= 1'b0;
      key_db_q      <= 1'b0;
      dbc_q         <= '0;
      state_q       <= WAIT_PRESS;
      div_cnt_q     <= '0;
      clock_en_q    <= 1'b0;
      pulse_count_q <= '0;
      heartbeat_q   <= 1'b0;
      step_mode_q   <= 1'b0;
    end else begin
      run_meta_q    <= run_meta_d;
      run_s_q       <= run_s_d;
      key_meta_q    <= key_meta_d;
      key_s_q       <= key_s_d;
      key_db_q      <= key_db_d;
      dbc_q         <= dbc_d;
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      clock_en_q    <= clock_en_d;
      pulse_count_q <= pulse_count_d;
      heartbeat_q   <= heartbeat_d;
      step_mode_q   <= step_mode_d;
    end
  end

  assign ClockEn        = clock_en_q;
  assign PulseCount     = pulse_count_q;
  assign Heartbeat      = heartbeat_q;
  assign StepMode       = step_mode_q;
  assign dbg_step_state = state_q;

endmodule
